// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : control_fsm
// Brief   : Multi-cycle sequencer for RV64 add/sub/and/or, ld, sd and beq.
//           Drives datapath strobes, paces memory via mem_ready, counts retires.
// Revision: 1.0 - initial release
// ============================================================================
module control_fsm #(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch_taken,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       op,
  output logic             flag,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_LD  = 2'd1,
    CLS_SD  = 2'd2,
    CLS_BEQ = 2'd3
  } cls_t;

  localparam logic [6:0] c_OPC_R   = 7'b0110011;
  localparam logic [6:0] c_OPC_LD  = 7'b0000011;
  localparam logic [6:0] c_OPC_SD  = 7'b0100011;
  localparam logic [6:0] c_OPC_BEQ = 7'b1100011;

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;

  localparam logic [1:0] c_CAUSE_NONE = 2'b00;
  localparam logic [1:0] c_CAUSE_ILL  = 2'b01;
  localparam logic [1:0] c_CAUSE_TMO  = 2'b10;

  // The counter only has to reach MEM_WAIT_MAX-1 before the timeout fires.
  localparam int                  c_WAIT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_WAIT_MAX - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  cls_t                r_cls;
  cls_t                w_cls;
  logic [3:0]          r_alu_op;
  logic [3:0]          w_alu_op;
  logic                w_legal;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                w_wait_clr;
  logic                w_wait_inc;
  logic [1:0]          r_trap_cause;
  logic                w_cause_set;
  logic [1:0]          w_cause_val;
  logic [CNT_W-1:0]    r_instr_count;

  assign trap_cause  = r_trap_cause;
  assign instr_count = r_instr_count;

  // Instruction decode from the live fields; only captured while in DECODE.
  always_comb begin
    w_legal  = 1'b0;
    w_cls    = CLS_R;
    w_alu_op = c_ALU_ADD;
    case (opcode)
      c_OPC_R: begin
        w_cls = CLS_R;
        case ({funct3, funct7_5})
          4'b000_0: begin w_legal = 1'b1; w_alu_op = c_ALU_ADD; end
          4'b000_1: begin w_legal = 1'b1; w_alu_op = c_ALU_SUB; end
          4'b111_0: begin w_legal = 1'b1; w_alu_op = c_ALU_AND; end
          4'b110_0: begin w_legal = 1'b1; w_alu_op = c_ALU_OR;  end
          default:  w_legal = 1'b0;
        endcase
      end
      c_OPC_LD: begin
        w_cls   = CLS_LD;
        w_legal = (funct3 == 3'b011);
      end
      c_OPC_SD: begin
        w_cls   = CLS_SD;
        w_legal = (funct3 == 3'b011);
      end
      c_OPC_BEQ: begin
        w_cls    = CLS_BEQ;
        w_alu_op = c_ALU_SUB;
        w_legal  = (funct3 == 3'b000);
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    op           = c_ALU_AND;
    flag         = 1'b0;
    mem_to_reg   = 1'b0;
    trap         = 1'b0;
    w_wait_clr   = 1'b0;
    w_wait_inc   = 1'b0;
    w_cause_set  = 1'b0;
    w_cause_val  = c_CAUSE_NONE;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        ir_write    = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_legal) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_TRAP;
          w_cause_set = 1'b1;
          w_cause_val = c_CAUSE_ILL;
        end
      end
      S_EXEC: begin
        op         = r_alu_op;
        w_wait_clr = 1'b1;
        case (r_cls)
          CLS_R:   w_state_nxt = S_WB;
          CLS_BEQ: begin
            pc_write     = 1'b1;
            branch_taken = zero;
            w_state_nxt  = S_FETCH;
          end
          default: w_state_nxt = S_MEM;
        endcase
      end
      S_MEM: begin
        op        = r_alu_op;
        mem_read  = (r_cls == CLS_LD);
        mem_write = (r_cls == CLS_SD);
        // Completion takes priority over the timeout on the final wait cycle.
        if (mem_ready) begin
          if (r_cls == CLS_SD) begin
            pc_write    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_state_nxt = S_TRAP;
          w_cause_set = 1'b1;
          w_cause_val = c_CAUSE_TMO;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WB: begin
        op          = r_alu_op;
        flag        = 1'b1;
        pc_write    = 1'b1;
        mem_to_reg  = (r_cls == CLS_LD);
        w_state_nxt = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls         <= CLS_R;
      r_alu_op      <= c_ALU_AND;
      r_wait_cnt    <= '0;
      r_trap_cause  <= c_CAUSE_NONE;
      r_instr_count <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_cls    <= w_cls;
        r_alu_op <= w_alu_op;
      end
      if (w_wait_clr) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
      end
      if (w_cause_set) begin
        r_trap_cause <= w_cause_val;
      end
      if (pc_write) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
